// File: rtl/ysyx_23060187_lsu.sv
// ysyx_23060187_lsu: load/store stage between execute and write-back, one instruction in flight
module ysyx_23060187_lsu #(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exu_lsu_valid,
    output logic        lsu_exu_ready,
    input  logic [31:0] exu_lsu_result,
    input  logic [31:0] exu_lsu_store_data,
    input  logic        exu_lsu_mem_rd,
    input  logic        exu_lsu_mem_wr,
    input  logic [2:0]  exu_lsu_funct3,
    input  logic [4:0]  exu_lsu_rd,
    input  logic        exu_lsu_wen,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata,
    output logic        lsu_wbu_valid,
    input  logic        wbu_lsu_ready,
    output logic [31:0] lsu_wbu_wdata,
    output logic [4:0]  lsu_wbu_rd,
    output logic        lsu_wbu_wen,
    output logic        lsu_wbu_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, WB} state_t;
    state_t      state;
    logic [1:0]  a_q;
    logic [2:0]  f3_q;
    logic        ld_q;
    logic        wen_q;
    logic [31:0] cnt;
    logic [1:0]  a;
    logic [2:0]  f;
    logic        is_mem;
    logic        bad;
    logic [31:0] st_data;
    logic [3:0]  st_mask;
    logic [31:0] sh;
    logic [31:0] ld_data;
    logic        timeout;
    // decode the incoming access, build store lanes and extract load data from the response
    always_comb begin
        a = exu_lsu_result[1:0];
        f = exu_lsu_funct3;
        is_mem = exu_lsu_mem_rd | exu_lsu_mem_wr;
        bad = (exu_lsu_mem_rd & exu_lsu_mem_wr) | (is_mem & (f == 3'b011 | f[2:1] == 2'b11 |
              (f[1:0] == 2'b01 & a[0]) | (f[1:0] == 2'b10 & a != 2'b00)));
        st_data = f[1:0] == 2'b00 ? {4{exu_lsu_store_data[7:0]}} :
                  f[1:0] == 2'b01 ? {2{exu_lsu_store_data[15:0]}} : exu_lsu_store_data;
        st_mask = f[1:0] == 2'b00 ? 4'b0001 << a :
                  f[1:0] == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
        sh = mem_rsp_rdata >> {a_q, 3'b000};
        ld_data = f3_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                  f3_q == 3'b100 ? {24'b0, sh[7:0]} :
                  f3_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
                  f3_q == 3'b101 ? {16'b0, sh[15:0]} : sh;
        timeout = RSP_TIMEOUT != 0 && cnt + 32'd1 == 32'(RSP_TIMEOUT);
    end
    // control FSM with registered bus and write-back outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lsu_exu_ready <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_req_addr <= '0;
            mem_req_wen <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
            lsu_wbu_valid <= 1'b0;
            lsu_wbu_wdata <= '0;
            lsu_wbu_rd <= '0;
            lsu_wbu_wen <= 1'b0;
            lsu_wbu_err <= 1'b0;
            a_q <= '0;
            f3_q <= '0;
            ld_q <= 1'b0;
            wen_q <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (exu_lsu_valid) begin
                    lsu_exu_ready <= 1'b0;
                    a_q <= a;
                    f3_q <= f;
                    ld_q <= exu_lsu_mem_rd;
                    wen_q <= exu_lsu_wen && exu_lsu_rd != 5'd0;
                    lsu_wbu_rd <= exu_lsu_rd;
                    lsu_wbu_err <= bad;
                    lsu_wbu_wen <= !is_mem && exu_lsu_wen;
                    lsu_wbu_wdata <= is_mem ? 32'd0 : exu_lsu_result;
                    mem_req_addr <= {exu_lsu_result[31:2], 2'b00};
                    mem_req_wen <= exu_lsu_mem_wr;
                    mem_req_wdata <= exu_lsu_mem_wr ? st_data : 32'd0;
                    mem_req_wmask <= exu_lsu_mem_wr ? st_mask : 4'd0;
                    mem_req_valid <= is_mem && !bad;
                    lsu_wbu_valid <= !is_mem || bad;
                    state <= (is_mem && !bad) ? REQ : WB;
                end
                REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state <= WAIT_RSP;
                end
                WAIT_RSP: if (mem_rsp_valid || timeout) begin
                    cnt <= '0;
                    state <= WB;
                    lsu_wbu_valid <= 1'b1;
                    lsu_wbu_err <= !mem_rsp_valid;
                    lsu_wbu_wen <= mem_rsp_valid && ld_q && wen_q;
                    lsu_wbu_wdata <= (mem_rsp_valid && ld_q) ? ld_data : 32'd0;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                WB: if (wbu_lsu_ready) begin
                    lsu_wbu_valid <= 1'b0;
                    lsu_exu_ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060187_lsu.sv
// tb_ysyx_23060187_lsu: directed self-checking bench for the load/store stage
module tb_ysyx_23060187_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        exu_lsu_valid;
    logic        lsu_exu_ready;
    logic [31:0] exu_lsu_result;
    logic [31:0] exu_lsu_store_data;
    logic        exu_lsu_mem_rd;
    logic        exu_lsu_mem_wr;
    logic [2:0]  exu_lsu_funct3;
    logic [4:0]  exu_lsu_rd;
    logic        exu_lsu_wen;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        lsu_wbu_valid;
    logic        wbu_lsu_ready;
    logic [31:0] lsu_wbu_wdata;
    logic [4:0]  lsu_wbu_rd;
    logic        lsu_wbu_wen;
    logic        lsu_wbu_err;
    int tests = 0;
    int failed = 0;

    ysyx_23060187_lsu #(.RSP_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .exu_lsu_valid(exu_lsu_valid), .lsu_exu_ready(lsu_exu_ready),
        .exu_lsu_result(exu_lsu_result), .exu_lsu_store_data(exu_lsu_store_data),
        .exu_lsu_mem_rd(exu_lsu_mem_rd), .exu_lsu_mem_wr(exu_lsu_mem_wr),
        .exu_lsu_funct3(exu_lsu_funct3), .exu_lsu_rd(exu_lsu_rd), .exu_lsu_wen(exu_lsu_wen),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .lsu_wbu_valid(lsu_wbu_valid), .wbu_lsu_ready(wbu_lsu_ready),
        .lsu_wbu_wdata(lsu_wbu_wdata), .lsu_wbu_rd(lsu_wbu_rd),
        .lsu_wbu_wen(lsu_wbu_wen), .lsu_wbu_err(lsu_wbu_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
        exu_lsu_valid = 1'b1;
        exu_lsu_mem_rd = ld;
        exu_lsu_mem_wr = st;
        exu_lsu_funct3 = f3;
        exu_lsu_result = addr;
        exu_lsu_store_data = data;
        exu_lsu_rd = rd;
        exu_lsu_wen = ld;
        tick();
        exu_lsu_valid = 1'b0;
    endtask

    // full memory access with immediate ready and response: write-back three cycles after acceptance
    task automatic mem_op(input string tag, input logic ld, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_mask, input logic [31:0] exp_wb, input logic exp_wen);
        issue(ld, !ld, f3, addr, data, rd);
        chk({tag, " req_valid"}, 32'(mem_req_valid), 32'd1);
        chk({tag, " req_addr"}, mem_req_addr, {addr[31:2], 2'b00});
        chk({tag, " req_wen"}, 32'(mem_req_wen), 32'(!ld));
        chk({tag, " req_wmask"}, 32'(mem_req_wmask), 32'(exp_mask));
        if (!ld) chk({tag, " req_wdata"}, mem_req_wdata, exp_wdata);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk({tag, " req_dropped"}, 32'(mem_req_valid), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        tick();
        mem_rsp_valid = 1'b0;
        chk({tag, " wb_valid"}, 32'(lsu_wbu_valid), 32'd1);
        chk({tag, " wb_wen"}, 32'(lsu_wbu_wen), 32'(exp_wen));
        chk({tag, " wb_err"}, 32'(lsu_wbu_err), 32'd0);
        if (ld) chk({tag, " wb_wdata"}, lsu_wbu_wdata, exp_wb);
        tick();
        chk({tag, " back_idle"}, 32'({lsu_wbu_valid, lsu_exu_ready}), 32'b01);
    endtask

    initial begin
        rst = 1'b1;
        exu_lsu_valid = 1'b0;
        exu_lsu_result = '0;
        exu_lsu_store_data = '0;
        exu_lsu_mem_rd = 1'b0;
        exu_lsu_mem_wr = 1'b0;
        exu_lsu_funct3 = '0;
        exu_lsu_rd = '0;
        exu_lsu_wen = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        wbu_lsu_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset ready", 32'(lsu_exu_ready), 32'd1);
        chk("reset req_valid", 32'(mem_req_valid), 32'd0);
        chk("reset wb_valid", 32'(lsu_wbu_valid), 32'd0);
        chk("reset wb_err", 32'(lsu_wbu_err), 32'd0);

        issue(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
        exu_lsu_wen = 1'b0;
        chk("alu wb_valid", 32'(lsu_wbu_valid), 32'd1);
        chk("alu wdata", lsu_wbu_wdata, 32'h1234_5678);
        chk("alu rd", 32'(lsu_wbu_rd), 32'd5);
        chk("alu wen", 32'(lsu_wbu_wen), 32'd0);
        chk("alu no_req", 32'(mem_req_valid), 32'd0);
        chk("alu ready_low", 32'(lsu_exu_ready), 32'd0);
        tick();
        chk("alu back_idle", 32'({lsu_wbu_valid, lsu_exu_ready}), 32'b01);

        exu_lsu_valid = 1'b1;
        exu_lsu_result = 32'h1234_5678;
        exu_lsu_rd = 5'd5;
        exu_lsu_wen = 1'b1;
        tick();
        exu_lsu_valid = 1'b0;
        chk("alu2 wen", 32'(lsu_wbu_wen), 32'd1);
        chk("alu2 wdata", lsu_wbu_wdata, 32'h1234_5678);
        tick();

        mem_op("lb", 1'b1, 3'b000, 32'h8000_0003, 32'h0, 5'd1, 32'h80AA_BBCC, 32'h0, 4'b0000, 32'hFFFF_FF80, 1'b1);
        mem_op("lbu", 1'b1, 3'b100, 32'h8000_0003, 32'h0, 5'd1, 32'h80AA_BBCC, 32'h0, 4'b0000, 32'h0000_0080, 1'b1);
        mem_op("lh", 1'b1, 3'b001, 32'h8000_0002, 32'h0, 5'd2, 32'h80AA_BBCC, 32'h0, 4'b0000, 32'hFFFF_80AA, 1'b1);
        mem_op("lhu", 1'b1, 3'b101, 32'h8000_0002, 32'h0, 5'd2, 32'h80AA_BBCC, 32'h0, 4'b0000, 32'h0000_80AA, 1'b1);
        mem_op("lw", 1'b1, 3'b010, 32'h0000_0010, 32'h0, 5'd7, 32'hCAFE_F00D, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b1);
        mem_op("lb_x0", 1'b1, 3'b000, 32'h0000_0001, 32'h0, 5'd0, 32'h80AA_BBCC, 32'h0, 4'b0000, 32'hFFFF_FFBB, 1'b0);
        mem_op("sb", 1'b0, 3'b000, 32'h0000_0001, 32'h1234_56A5, 5'd0, 32'h0, 32'hA5A5_A5A5, 4'b0010, 32'h0, 1'b0);
        mem_op("sw", 1'b0, 3'b010, 32'h0000_0204, 32'h0BAD_F00D, 5'd0, 32'h0, 32'h0BAD_F00D, 4'b1111, 32'h0, 1'b0);

        issue(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hDEAD_BEEF, 5'd0);
        for (int i = 0; i < 4; i++) begin
            chk("sh stall valid", 32'(mem_req_valid), 32'd1);
            chk("sh stall addr", mem_req_addr, 32'h0000_0100);
            chk("sh stall wdata", mem_req_wdata, 32'hBEEF_BEEF);
            chk("sh stall wmask", 32'(mem_req_wmask), 32'b1100);
            chk("sh stall wen", 32'(mem_req_wen), 32'd1);
            if (i == 3) mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        chk("sh wb_valid", 32'(lsu_wbu_valid), 32'd1);
        chk("sh wb_wen", 32'(lsu_wbu_wen), 32'd0);
        chk("sh wb_err", 32'(lsu_wbu_err), 32'd0);
        tick();

        issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd3);
        chk("misalign wb_valid", 32'(lsu_wbu_valid), 32'd1);
        chk("misalign err", 32'(lsu_wbu_err), 32'd1);
        chk("misalign wen", 32'(lsu_wbu_wen), 32'd0);
        chk("misalign no_req", 32'(mem_req_valid), 32'd0);
        tick();
        chk("misalign req_later", 32'(mem_req_valid), 32'd0);

        issue(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd3);
        chk("rdwr err", 32'(lsu_wbu_err), 32'd1);
        chk("rdwr no_req", 32'(mem_req_valid), 32'd0);
        tick();
        issue(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd3);
        chk("f3 illegal err", 32'(lsu_wbu_err), 32'd1);
        chk("f3 illegal valid", 32'(lsu_wbu_valid), 32'd1);
        tick();

        issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd3);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        wbu_lsu_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("timeout pending", 32'(lsu_wbu_valid), 32'd0);
            tick();
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("timeout wb_valid", 32'(lsu_wbu_valid), 32'd1);
            chk("timeout err", 32'(lsu_wbu_err), 32'd1);
            chk("timeout wen", 32'(lsu_wbu_wen), 32'd0);
            chk("timeout rd", 32'(lsu_wbu_rd), 32'd3);
            chk("timeout ready_low", 32'(lsu_exu_ready), 32'd0);
            if (i == 2) wbu_lsu_ready = 1'b1;
            tick();
        end
        chk("timeout released", 32'({lsu_wbu_valid, lsu_exu_ready}), 32'b01);

        issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd4);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst ready", 32'(lsu_exu_ready), 32'd1);
        chk("rst req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst wb_valid", 32'(lsu_wbu_valid), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h5555_AAAA;
        tick();
        mem_rsp_valid = 1'b0;
        chk("stale rsp wb_valid", 32'(lsu_wbu_valid), 32'd0);
        chk("stale rsp ready", 32'(lsu_exu_ready), 32'd1);
        tick();
        chk("stale rsp later", 32'(lsu_wbu_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/ysyx_23060187_lsu.md
Name: ysyx_23060187_lsu

Overview:
Load/store stage that sits directly downstream of the execute stage in the multicycle RV32 core and upstream of write-back. It accepts one instruction at a time over a valid/ready handshake, performs at most one memory access over a request/response bus, aligns and extends load data, and hands a register write result to write-back. Non-memory instructions pass through with a single-cycle delay.

Parameters:
RSP_TIMEOUT, 255, max cycles spent in WAIT_RSP before abandoning the access with error; 0 disables the timeout.

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
exu_lsu_valid  input  1  execute stage presents an instruction
lsu_exu_ready  output  1  LSU can accept; high only in IDLE
exu_lsu_result  input  32  ALU result: effective address for load/store, write data otherwise
exu_lsu_store_data  input  32  rs2 value for stores
exu_lsu_mem_rd  input  1  instruction is a load
exu_lsu_mem_wr  input  1  instruction is a store (both set: error)
exu_lsu_funct3  input  3  RISC-V funct3 size/sign code
exu_lsu_rd  input  5  destination register
exu_lsu_wen  input  1  instruction writes rd
mem_req_valid  output  1  memory request pending
mem_req_ready  input  1  memory accepts the request
mem_req_addr  output  32  word-aligned address ({addr[31:2],2'b00})
mem_req_wen  output  1  1 = write
mem_req_wdata  output  32  lane-shifted store data
mem_req_wmask  output  4  byte-lane write strobes; 0 for reads
mem_rsp_valid  input  1  read data / write acknowledge
mem_rsp_rdata  input  32  read word
lsu_wbu_valid  output  1  result available for write-back
wbu_lsu_ready  input  1  write-back consumes the result
lsu_wbu_wdata  output  32  value to write to rd
lsu_wbu_rd  output  5  destination register
lsu_wbu_wen  output  1  register write enable
lsu_wbu_err  output  1  misaligned, illegal funct3, or timeout

Behaviour:
- States: IDLE, REQ, WAIT_RSP, WB. Reset → IDLE; all outputs 0 except lsu_exu_ready=1; the timeout counter clears.
- IDLE: lsu_exu_ready=1. On exu_lsu_valid, all inputs are captured into registers.
  - Non-memory instruction: next state is WB with wdata=result.
  - Memory instruction with a legal, aligned access: next state is REQ.
  - Error (both rd and wr set, illegal funct3 011/110/111, or misalignment): next state is WB with err=1 and wen=0. No memory access is made.
- Alignment rules: halfword (funct3 x01) requires addr[0]=0. Word (010) requires addr[1:0]=00. Byte accesses are always aligned.
- REQ: mem_req_valid=1 with stable addr, wen, wdata and wmask until mem_req_ready is sampled high. On that cycle the next state is WAIT_RSP.
- Store lanes:
  - SB: wdata={4{data[7:0]}}, wmask=0001<<addr[1:0].
  - SH: wdata={2{data[15:0]}}, wmask=0011<<{addr[1],1'b0}.
  - SW: wmask=1111.
- WAIT_RSP:
  - mem_rsp_valid is only honoured in this state. A response in the same cycle as the request handshake is a protocol violation and is ignored.
  - On mem_rsp_valid the next state is WB. A load sets wdata=extracted data and wen=captured wen. A store sets wen=0.
- Load extraction: shift rdata right by addr[1:0]*8.
  - LB/LH: sign-extend bit 7 or bit 15.
  - LBU/LHU: zero-extend.
  - LW: full word.
  - A load with rd=0 still has wen forced to 0.
- Timeout: the counter increments each cycle in WAIT_RSP. When it reaches RSP_TIMEOUT (if nonzero), the next state is WB with err=1 and wen=0. The counter clears on leaving WAIT_RSP.
- WB: lsu_wbu_valid=1 and outputs hold stable until wbu_lsu_ready is high. Then the next state is IDLE, valid drops, and lsu_exu_ready rises in the following cycle.
- Latency (IDLE acceptance at cycle N):
  - Non-memory/error: lsu_wbu_valid at N+1.
  - Memory with ready at N+1 and response at N+2: lsu_wbu_valid at N+3.
- rst high in any state returns the block to IDLE at the next edge. mem_req_valid and lsu_wbu_valid drop that cycle. A late memory response after reset is ignored.

Test Plan:
- Non-memory pass-through: result=0x1234_5678, rd=5, wen=1 → lsu_wbu_valid 1 cycle later, wdata=0x12345678, rd=5, wen=1, no mem_req_valid.
- LB at addr 0x8000_0003, rdata=0x80AA_BBCC → mem_req_addr=0x8000_0000, wmask=0, wdata=0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- SH at addr 0x102, data 0xDEAD_BEEF, mem_req_ready held low 3 cycles → request stable 4 cycles, wdata=0xBEEF_BEEF, wmask=1100, wbu wen=0.
- LW at addr 0x101 → no mem_req_valid, lsu_wbu_err=1, wen=0, valid 1 cycle after acceptance.
- RSP_TIMEOUT=4 with no response → err=1 exactly 4 cycles after entering WAIT_RSP. wbu_lsu_ready held low 2 cycles → outputs stable, lsu_exu_ready low throughout.
- rst asserted during WAIT_RSP, then a response arrives → next cycle IDLE with ready=1, and the stale response produces no lsu_wbu_valid.
